// File: rtl/proc_pkg.sv
// Shared definitions for the processor memory-port logic: arbiter FSM
// state encoding and the transaction-owner constants.
package proc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU control unit and a
// DMA/program-loader requester. Every access is a fixed four-cycle
// IDLE -> ISSUE -> RESP -> DONE sequence. The CPU has fixed priority, but a
// starvation counter forces a DMA grant once the CPU has won MAX_BURST times
// in a row while DMA was waiting.
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner_dma
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  arb_state_t        state_reg, state_next;
  logic [3:0]        starve_cnt_reg, starve_cnt_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              mem_en_next, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              owner_next;
  logic              cpu_ack_next, dma_ack_next;
  logic              grant_dma;

  // Both requesters see the captured word; only the acked side consumes it.
  assign cpu_rdata = rdata_reg;
  assign dma_rdata = rdata_reg;

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    rdata_next      = rdata_reg;
    mem_en_next     = 1'b0;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    owner_next      = owner_dma;
    cpu_ack_next    = 1'b0;
    dma_ack_next    = 1'b0;
    grant_dma       = dma_req && (!cpu_req || (starve_cnt_reg == BURST_LIMIT));

    case (state_reg)
      ARB_IDLE: begin
        owner_next = OWN_CPU;
        if (!dma_req) begin
          starve_cnt_next = 4'd0;
        end
        if (cpu_req || dma_req) begin
          state_next  = ARB_ISSUE;
          mem_en_next = 1'b1;
          if (grant_dma) begin
            mem_we_next     = dma_we;
            mem_addr_next   = dma_addr;
            mem_wdata_next  = dma_wdata;
            owner_next      = OWN_DMA;
            starve_cnt_next = 4'd0;
          end else begin
            mem_we_next    = cpu_we;
            mem_addr_next  = cpu_addr;
            mem_wdata_next = cpu_wdata;
            owner_next     = OWN_CPU;
            if (dma_req) begin
              starve_cnt_next = (starve_cnt_reg >= BURST_LIMIT) ?
                                BURST_LIMIT : starve_cnt_reg + 4'd1;
            end
          end
        end
      end
      ARB_ISSUE: begin
        // Memory samples the access at the end of this cycle.
        state_next = ARB_RESP;
      end
      ARB_RESP: begin
        rdata_next   = mem_rdata;
        cpu_ack_next = (owner_dma == OWN_CPU);
        dma_ack_next = (owner_dma == OWN_DMA);
        state_next   = ARB_DONE;
      end
      ARB_DONE: begin
        owner_next = OWN_CPU;
        state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ARB_IDLE;
      starve_cnt_reg <= 4'd0;
      rdata_reg      <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      owner_dma      <= 1'b0;
      cpu_ack        <= 1'b0;
      dma_ack        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      rdata_reg      <= rdata_next;
      mem_en         <= mem_en_next;
      mem_we         <= mem_we_next;
      mem_addr       <= mem_addr_next;
      mem_wdata      <= mem_wdata_next;
      owner_dma      <= owner_next;
      cpu_ack        <= cpu_ack_next;
      dma_ack        <= dma_ack_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous-read memory.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [9:0]  dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        owner_dma;

  logic        preload;
  logic [31:0] mem_array [0:1023];

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(10), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner_dma(owner_dma)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      0:       return 32'h0000_0011;
      5:       return 32'h0000_00AA;
      6:       return 32'h0000_0066;
      default: return 32'h0;
    endcase
  endfunction

  // Single-port memory with registered read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem_array[i] <= init_word(i);
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) mem_array[mem_addr] <= mem_wdata;
      mem_rdata <= mem_array[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the first ack; cycles = -1 on timeout.
  task automatic wait_ack(output int cycles, output logic who);
    cycles = -1;
    who    = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (cpu_ack || dma_ack) begin
        cycles = i;
        who    = dma_ack;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; preload = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    tick(); tick();
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en got %0b want 0", mem_en); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 10'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (owner_dma !== 1'b0) begin n_err++; $display("FAIL reset_owner got %0b want 0", owner_dma); end
    n_cmp++; if ({cpu_ack, dma_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks got %b want 00", {cpu_ack, dma_ack}); end
    preload = 1'b0; reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
    tick();
    n_cmp++; if ({mem_en, mem_we} !== 2'b10) begin n_err++; $display("FAIL rd_issue_strobes got %b want 10", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 10'h005) begin n_err++; $display("FAIL rd_issue_addr got %h want 005", mem_addr); end
    n_cmp++; if ({cpu_ack, owner_dma} !== 2'b00) begin n_err++; $display("FAIL rd_issue_ack_owner got %b want 00", {cpu_ack, owner_dma}); end
    tick();
    n_cmp++; if ({mem_en, cpu_ack} !== 2'b00) begin n_err++; $display("FAIL rd_resp_en_ack got %b want 00", {mem_en, cpu_ack}); end
    tick();
    n_cmp++; if ({cpu_ack, dma_ack} !== 2'b10) begin n_err++; $display("FAIL rd_done_acks got %b want 10", {cpu_ack, dma_ack}); end
    n_cmp++; if (cpu_rdata !== 32'h0000_00AA) begin n_err++; $display("FAIL rd_done_rdata got %h want 000000aa", cpu_rdata); end
    cpu_req = 0;
    tick();
    n_cmp++; if ({cpu_ack, mem_en} !== 2'b00) begin n_err++; $display("FAIL rd_after_ack got %b want 00", {cpu_ack, mem_en}); end
    $display("test_cpu_read done");
  endtask

  task automatic test_dma_write_cpu_read();
    int   cyc;
    logic who;
    dma_req = 1; dma_we = 1; dma_addr = 10'h3FF; dma_wdata = 32'hDEAD_BEEF;
    tick();
    n_cmp++; if ({owner_dma, mem_en, mem_we} !== 3'b111) begin n_err++; $display("FAIL dw_issue owner/en/we got %b want 111", {owner_dma, mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 10'h3FF) begin n_err++; $display("FAIL dw_issue_addr got %h want 3ff", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL dw_issue_wdata got %h want deadbeef", mem_wdata); end
    tick(); tick();
    n_cmp++; if ({dma_ack, cpu_ack, owner_dma} !== 3'b101) begin n_err++; $display("FAIL dw_done dack/cack/owner got %b want 101", {dma_ack, cpu_ack, owner_dma}); end
    dma_req = 0; dma_we = 0;
    tick();
    n_cmp++; if ({owner_dma, dma_ack} !== 2'b00) begin n_err++; $display("FAIL dw_after owner/ack got %b want 00", {owner_dma, dma_ack}); end
    n_cmp++; if (mem_array[1023] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL dw_mem_3ff got %h want deadbeef", mem_array[1023]); end
    n_cmp++; if (mem_array[0] !== 32'h0000_0011) begin n_err++; $display("FAIL dw_mem_000 got %h want 00000011", mem_array[0]); end
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h3FF;
    wait_ack(cyc, who);
    n_cmp++; if (cyc !== 3 || who !== 1'b0) begin n_err++; $display("FAIL cr_latency got cyc=%0d dma=%0b want cyc=3 dma=0", cyc, who); end
    n_cmp++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cr_rdata got %h want deadbeef", cpu_rdata); end
    n_cmp++; if (owner_dma !== 1'b0) begin n_err++; $display("FAIL cr_owner got %b want 0", owner_dma); end
    cpu_req = 0;
    tick();
    $display("test_dma_write_cpu_read done");
  endtask

  task automatic test_starvation();
    logic exp_c, exp_d;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h001;
    dma_req = 1; dma_we = 0; dma_addr = 10'h002;
    for (int c = 1; c <= 27; c++) begin
      tick();
      exp_c = (c == 3) || (c == 7) || (c == 11) || (c == 15) || (c == 23) || (c == 27);
      exp_d = (c == 19);
      n_cmp++;
      if ({cpu_ack, dma_ack} !== {exp_c, exp_d}) begin
        n_err++;
        $display("FAIL starve_cycle%0d acks got %b want %b", c, {cpu_ack, dma_ack}, {exp_c, exp_d});
      end
    end
    cpu_req = 0; dma_req = 0;
    tick(); tick();
    $display("test_starvation done");
  endtask

  task automatic test_no_forced_dma();
    int   cyc;
    logic who;
    for (int t = 0; t < 6; t++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
      dma_req = 1; dma_we = 0; dma_addr = 10'h006;
      wait_ack(cyc, who);
      n_cmp++;
      if (cyc !== 3 || who !== 1'b0) begin
        n_err++;
        $display("FAIL nofdma_txn%0d got cyc=%0d dma=%0b want cyc=3 dma=0", t, cyc, who);
      end
      cpu_req = 0; dma_req = 0;
      tick(); tick();
    end
    $display("test_no_forced_dma done");
  endtask

  task automatic test_reset_mid();
    int   cyc;
    int   acks;
    int   we_seen;
    logic who;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 32'h1234_5678;
    tick();
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL rm_issue_we got %b want 1", mem_we); end
    tick();
    reset = 1;
    tick();
    n_cmp++; if ({mem_en, mem_we, owner_dma, cpu_ack, dma_ack} !== 5'b0) begin n_err++; $display("FAIL rm_strobes got %b want 00000", {mem_en, mem_we, owner_dma, cpu_ack, dma_ack}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 42'h0) begin n_err++; $display("FAIL rm_addr_wdata got %h/%h want 0/0", mem_addr, mem_wdata); end
    reset = 0; cpu_req = 0; cpu_we = 0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack || dma_ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL rm_no_ack got %0d acks want 0", acks); end
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
    wait_ack(cyc, who);
    n_cmp++; if (cyc !== 3 || cpu_rdata !== 32'h0000_00AA) begin n_err++; $display("FAIL rm_recover got cyc=%0d rdata=%h want 3/000000aa", cyc, cpu_rdata); end
    cpu_req = 0;
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h020; cpu_wdata = 32'h5555_5555;
    reset = 1;
    we_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_we) we_seen++;
    end
    cpu_req = 0; cpu_we = 0; reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_we) we_seen++;
    end
    n_cmp++; if (we_seen !== 0) begin n_err++; $display("FAIL ri_mem_we got %0d cycles want 0", we_seen); end
    n_cmp++; if (mem_array[32] !== 32'h0) begin n_err++; $display("FAIL ri_mem_020 got %h want 0", mem_array[32]); end
    $display("test_reset_mid done");
  endtask

  task automatic test_req_drop();
    int   cyc;
    int   acks;
    int   ens;
    logic who;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
    tick();
    cpu_req = 0; cpu_addr = 10'h006;
    n_cmp++; if (mem_addr !== 10'h005) begin n_err++; $display("FAIL rd_drop_issue_addr got %h want 005", mem_addr); end
    tick();
    n_cmp++; if (mem_addr !== 10'h005) begin n_err++; $display("FAIL rd_drop_resp_addr got %h want 005", mem_addr); end
    tick();
    n_cmp++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h0000_00AA) begin n_err++; $display("FAIL rd_drop_done got ack=%b rdata=%h want 1/000000aa", cpu_ack, cpu_rdata); end
    acks = 0; ens = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack || dma_ack) acks++;
      if (mem_en) ens++;
    end
    n_cmp++; if (acks !== 0 || ens !== 0) begin n_err++; $display("FAIL rd_drop_idle got acks=%0d en=%0d want 0/0", acks, ens); end
    cpu_req = 1;
    wait_ack(cyc, who);
    n_cmp++; if (cyc !== 3 || cpu_rdata !== 32'h0000_0066) begin n_err++; $display("FAIL rd_drop_new got cyc=%0d rdata=%h want 3/00000066", cyc, cpu_rdata); end
    cpu_req = 0;
    tick();
    $display("test_req_drop done");
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write_cpu_read();
    test_starvation();
    test_no_forced_dma();
    test_reset_mid();
    test_req_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
